mips_multicycle_control: RTL and testbench

- Main control FSM of the multicycle MIPS datapath. Sits directly upstream of the ALU and drives its 3-bit select plus all datapath mux and enable signals.
- Sequences each instruction through fetch, decode, execute, memory and writeback, using the ALU's opcode set (add, and, or, xor, not, shl1, shr1, zero) and its zero flag.
- The ALU has no subtract, so beq/bne compare operands with XOR and test the zero flag.

---
 rtl/mips_multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives the ALU select, datapath muxes and enables.
module mips_multicycle_control #(
   parameter int OPW = 6
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] funct,
   input  logic           zero,
   output logic [2:0]     alu_select,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic           ext_zero,
   output logic           iord,
   output logic           mem_read,
   output logic           mem_write,
   output logic           ir_write,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           reg_write,
   output logic [1:0]     pc_source,
   output logic           pc_en,
   output logic           illegal_op,
   output logic [3:0]     state_dbg
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      I_EXEC   = 4'd8,
      I_WB     = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [OPW-1:0] OP_RTYPE = OPW'('h00);
   localparam logic [OPW-1:0] OP_J     = OPW'('h02);
   localparam logic [OPW-1:0] OP_BEQ   = OPW'('h04);
   localparam logic [OPW-1:0] OP_BNE   = OPW'('h05);
   localparam logic [OPW-1:0] OP_ADDI  = OPW'('h08);
   localparam logic [OPW-1:0] OP_ANDI  = OPW'('h0C);
   localparam logic [OPW-1:0] OP_ORI   = OPW'('h0D);
   localparam logic [OPW-1:0] OP_XORI  = OPW'('h0E);
   localparam logic [OPW-1:0] OP_LW    = OPW'('h23);
   localparam logic [OPW-1:0] OP_SW    = OPW'('h2B);
   localparam logic [OPW-1:0] F_ADD    = OPW'('h20);
   localparam logic [OPW-1:0] F_AND    = OPW'('h24);
   localparam logic [OPW-1:0] F_OR     = OPW'('h25);
   localparam logic [OPW-1:0] F_XOR    = OPW'('h26);

   state_t state, state_next;

   // NOTE: state register uses non-blocking assignments; the combinational block below uses blocking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_next;
   end

   assign state_dbg = state;

   always_comb begin
      // NOTE: every output and state_next gets a default first so no latch is inferred.
      state_next = FETCH;
      alu_select = 3'b000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      ext_zero   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      pc_source  = 2'b00;
      pc_en      = 1'b0;
      illegal_op = 1'b0;

      // Outputs are forced to their idle values for as long as reset is held.
      if (reset) begin
         case (state)
            FETCH: begin
               mem_read   = 1'b1;
               ir_write   = 1'b1;
               alu_src_b  = 2'b01;
               pc_en      = 1'b1;
               state_next = DECODE;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               case (opcode)
                  OP_LW, OP_SW: state_next = MEM_ADDR;
                  OP_RTYPE: begin
                     case (funct)
                        F_ADD, F_AND, F_OR, F_XOR: state_next = R_EXEC;
                        default:                   illegal_op = 1'b1;
                     endcase
                  end
                  OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_next = I_EXEC;
                  OP_BEQ, OP_BNE:                    state_next = BRANCH;
                  OP_J:                              state_next = JUMP;
                  default:                           illegal_op = 1'b1;
               endcase
            end
            MEM_ADDR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
               iord       = 1'b1;
               mem_read   = 1'b1;
               state_next = MEM_WB;
            end
            MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEM_WR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
            end
            R_EXEC: begin
               alu_src_a  = 1'b1;
               state_next = R_WB;
               case (funct)
                  F_AND:   alu_select = 3'b001;
                  F_OR:    alu_select = 3'b010;
                  F_XOR:   alu_select = 3'b011;
                  default: alu_select = 3'b000;
               endcase
            end
            R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            I_EXEC: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'b10;
               ext_zero   = (opcode != OP_ADDI);
               state_next = I_WB;
               case (opcode)
                  OP_ANDI: alu_select = 3'b001;
                  OP_ORI:  alu_select = 3'b010;
                  OP_XORI: alu_select = 3'b011;
                  default: alu_select = 3'b000;
               endcase
            end
            I_WB:   reg_write = 1'b1;
            BRANCH: begin
               // No subtract in the ALU: XOR the operands and branch on the zero flag.
               alu_src_a  = 1'b1;
               alu_select = 3'b011;
               pc_source  = 2'b01;
               pc_en      = (opcode == OP_BNE) ? ~zero : zero;
            end
            JUMP: begin
               pc_source = 2'b10;
               pc_en     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle vector table plus
// hand-written latency and asynchronous-reset sequences.
module tb_mips_multicycle_control;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic [2:0] alu_select;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ext_zero;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic [1:0] pc_source;
   logic       pc_en;
   logic       illegal_op;
   logic [3:0] state_dbg;

   mips_multicycle_control #(.OPW(6)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .alu_select (alu_select),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .ext_zero   (ext_zero),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .pc_source  (pc_source),
      .pc_en      (pc_en),
      .illegal_op (illegal_op),
      .state_dbg  (state_dbg)
   );

   // Packed view: {sel,a,b,ez,iord,mr,mw,irw,rd,m2r,rw,pcs,pce,ill,state}
   logic [21:0] act;
   assign act = {alu_select, alu_src_a, alu_src_b, ext_zero, iord, mem_read, mem_write,
                 ir_write, reg_dst, mem_to_reg, reg_write, pc_source, pc_en, illegal_op,
                 state_dbg};

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic [21:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [21:0] mk(input logic [2:0] sel, input logic a, input logic [1:0] b,
                                      input logic ez, input logic io, input logic mr,
                                      input logic mw, input logic irw, input logic rd,
                                      input logic m2r, input logic rw, input logic [1:0] pcs,
                                      input logic pce, input logic ill, input logic [3:0] st);
      return {sel, a, b, ez, io, mr, mw, irw, rd, m2r, rw, pcs, pce, ill, st};
   endfunction

   task automatic check(input string name, input logic [21:0] actual, input logic [21:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic [21:0] e);
      vec_t v;
      v.rst = r;
      v.op  = op;
      v.fn  = fn;
      v.z   = z;
      v.exp = e;
      vecs.push_back(v);
   endtask

   // Runs one instruction from a fresh FETCH and counts clocks until FETCH returns.
   task automatic latency(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input int expected);
      int cycles;
      @(negedge clk);
      reset = 1'b0;
      #1;
      reset  = 1'b1;
      opcode = op;
      funct  = fn;
      zero   = 1'b0;
      cycles = 0;
      do begin
         @(posedge clk);
         cycles++;
         #1;
      end while (state_dbg != 4'd0 && cycles < 20);
      check(name, 22'(cycles), 22'(expected));
   endtask

   logic [21:0] e_rst, e_fetch, e_dec, e_ill, e_maddr, e_mrd, e_mwb, e_mwr;
   logic [21:0] e_rwb, e_iwb, e_br1, e_br0, e_jmp;

   initial begin
      reset  = 1'b0;
      opcode = 6'h00;
      funct  = 6'h00;
      zero   = 1'b0;

      e_rst   = '0;
      e_fetch = mk(3'd0, 1'b0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1, 0, 4'd0);
      e_dec   = mk(3'd0, 1'b0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd1);
      e_ill   = mk(3'd0, 1'b0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 4'd1);
      e_maddr = mk(3'd0, 1'b1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd2);
      e_mrd   = mk(3'd0, 1'b0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd3);
      e_mwb   = mk(3'd0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 4'd4);
      e_mwr   = mk(3'd0, 1'b0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 4'd5);
      e_rwb   = mk(3'd0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0, 4'd7);
      e_iwb   = mk(3'd0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'd9);
      e_br1   = mk(3'd3, 1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0, 4'd10);
      e_br0   = mk(3'd3, 1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 4'd10);
      e_jmp   = mk(3'd0, 1'b0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 4'd11);

      // reset held, then lw
      add(0, 6'h23, 6'h00, 0, e_rst);
      add(0, 6'h23, 6'h00, 0, e_rst);
      add(1, 6'h23, 6'h00, 0, e_fetch);
      add(1, 6'h23, 6'h00, 0, e_dec);
      add(1, 6'h23, 6'h00, 0, e_maddr);
      add(1, 6'h23, 6'h00, 0, e_mrd);
      add(1, 6'h23, 6'h00, 0, e_mwb);
      // sw
      add(1, 6'h2B, 6'h00, 0, e_fetch);
      add(1, 6'h2B, 6'h00, 0, e_dec);
      add(1, 6'h2B, 6'h00, 0, e_maddr);
      add(1, 6'h2B, 6'h00, 0, e_mwr);
      // R-type xor, add
      add(1, 6'h00, 6'h26, 0, e_fetch);
      add(1, 6'h00, 6'h26, 0, e_dec);
      add(1, 6'h00, 6'h26, 0, mk(3'd3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd6));
      add(1, 6'h00, 6'h26, 0, e_rwb);
      add(1, 6'h00, 6'h20, 0, e_fetch);
      add(1, 6'h00, 6'h20, 0, e_dec);
      add(1, 6'h00, 6'h20, 0, mk(3'd0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd6));
      add(1, 6'h00, 6'h20, 0, e_rwb);
      // ori, addi, andi
      add(1, 6'h0D, 6'h00, 0, e_fetch);
      add(1, 6'h0D, 6'h00, 0, e_dec);
      add(1, 6'h0D, 6'h00, 0, mk(3'd2, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd8));
      add(1, 6'h0D, 6'h00, 0, e_iwb);
      add(1, 6'h08, 6'h00, 0, e_fetch);
      add(1, 6'h08, 6'h00, 0, e_dec);
      add(1, 6'h08, 6'h00, 0, mk(3'd0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd8));
      add(1, 6'h08, 6'h00, 0, e_iwb);
      add(1, 6'h0C, 6'h00, 0, e_fetch);
      add(1, 6'h0C, 6'h00, 0, e_dec);
      add(1, 6'h0C, 6'h00, 0, mk(3'd1, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd8));
      add(1, 6'h0C, 6'h00, 0, e_iwb);
      // branches: beq z=1, bne z=1, bne z=0, beq z=0
      add(1, 6'h04, 6'h00, 1, e_fetch);
      add(1, 6'h04, 6'h00, 1, e_dec);
      add(1, 6'h04, 6'h00, 1, e_br1);
      add(1, 6'h05, 6'h00, 1, e_fetch);
      add(1, 6'h05, 6'h00, 1, e_dec);
      add(1, 6'h05, 6'h00, 1, e_br0);
      add(1, 6'h05, 6'h00, 0, e_fetch);
      add(1, 6'h05, 6'h00, 0, e_dec);
      add(1, 6'h05, 6'h00, 0, e_br1);
      add(1, 6'h04, 6'h00, 0, e_fetch);
      add(1, 6'h04, 6'h00, 0, e_dec);
      add(1, 6'h04, 6'h00, 0, e_br0);
      // jump
      add(1, 6'h02, 6'h00, 0, e_fetch);
      add(1, 6'h02, 6'h00, 0, e_dec);
      add(1, 6'h02, 6'h00, 0, e_jmp);
      // illegal opcode, illegal funct
      add(1, 6'h3F, 6'h00, 0, e_fetch);
      add(1, 6'h3F, 6'h00, 0, e_ill);
      add(1, 6'h00, 6'h22, 0, e_fetch);
      add(1, 6'h00, 6'h22, 0, e_ill);
      // and; reset asserted in R_EXEC, then sw from a clean FETCH
      add(1, 6'h00, 6'h24, 0, e_fetch);
      add(1, 6'h00, 6'h24, 0, e_dec);
      add(1, 6'h00, 6'h24, 0, mk(3'd1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'd6));
      add(0, 6'h00, 6'h24, 0, e_rst);
      add(0, 6'h2B, 6'h00, 0, e_rst);
      add(1, 6'h2B, 6'h00, 0, e_fetch);
      add(1, 6'h2B, 6'h00, 0, e_dec);
      add(1, 6'h2B, 6'h00, 0, e_maddr);
      add(1, 6'h2B, 6'h00, 0, e_mwr);
      add(1, 6'h2B, 6'h00, 0, e_fetch);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset  = vecs[i].rst;
         opcode = vecs[i].op;
         funct  = vecs[i].fn;
         zero   = vecs[i].z;
         #1;
         check($sformatf("vec%0d", i), act, vecs[i].exp);
      end

      latency("lat_lw",    6'h23, 6'h00, 5);
      latency("lat_sw",    6'h2B, 6'h00, 4);
      latency("lat_rtype", 6'h00, 6'h25, 4);
      latency("lat_xori",  6'h0E, 6'h00, 4);
      latency("lat_beq",   6'h04, 6'h00, 3);
      latency("lat_j",     6'h02, 6'h00, 3);
      latency("lat_ill",   6'h3F, 6'h00, 2);

      // Reset dropped asynchronously in the middle of MEM_RD.
      @(negedge clk);
      reset = 1'b0;
      #1;
      reset  = 1'b1;
      opcode = 6'h23;
      funct  = 6'h00;
      repeat (3) @(posedge clk);
      #3;
      check("async_pre_state", 22'(state_dbg), 22'd3);
      reset = 1'b0;
      #1;
      check("async_rst_outs", act, e_rst);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_release_fetch", act, e_fetch);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
